generador_inmediato_pipe: RTL and testbench

- Pipelined, parametrised immediate generator for the RV32I/RV64I decode path.
- Decodes all five immediate formats (I, S, B, U, J) and sign-extends the immediate to XLEN.
- Computes the PC-relative target for branch, JAL and AUIPC instructions.
- Carries results through a configurable number of elastic valid/ready register stages, with flush.
- Sits between instruction fetch and the register-read/execute stage.

---
 rtl/generador_inmediato_pipe_if.sv | 32 +++
 rtl/generador_inmediato_pipe.sv | 149 ++++++++++++++
 tb/tb_generador_inmediato_pipe.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/generador_inmediato_pipe_if.sv
// Handshake and payload bundle for the immediate generator: upstream
// instruction/PC offer, downstream decoded result, plus flush.
interface generador_inmediato_pipe_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned ILEN  = 32;
  localparam int unsigned FMT_W = 3;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [ILEN-1:0]   instruction;
  logic [XLEN-1:0]   pc;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   Imm;
  logic [FMT_W-1:0]  fmt;
  logic [XLEN-1:0]   target;
  logic              illegal;

  // Producer/consumer side (drives instructions, accepts results)
  modport master (
    output flush, in_valid, instruction, pc, out_ready,
    input  in_ready, out_valid, Imm, fmt, target, illegal
  );

  // Generator side
  modport slave (
    input  flush, in_valid, instruction, pc, out_ready,
    output in_ready, out_valid, Imm, fmt, target, illegal
  );
endinterface

// File: rtl/generador_inmediato_pipe.sv
// Pipelined RV32I/RV64I immediate generator: decodes the immediate format,
// sign-extends to XLEN, computes PC-relative targets and carries the result
// through STAGES elastic valid/ready register stages with flush.
module generador_inmediato_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  generador_inmediato_pipe_if.slave bus
);

  localparam int unsigned ILEN  = 32;
  localparam int unsigned FMT_W = 3;

  typedef enum logic [FMT_W-1:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  target;
    logic [FMT_W-1:0] fmt;
    logic             illegal;
  } entry_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [ILEN-1:0]   ins;
  logic [ILEN-1:0]   imm32;
  logic              pc_rel;
  entry_t            dec;

  entry_t            data_q   [STAGES];
  entry_t            up_data  [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] up_valid;
  logic [STAGES-1:0] ld;

  assign ins = bus.instruction;

  // Combinational decode of the offered instruction (captured into stage 1)
  always_comb begin
    dec     = '0;
    imm32   = '0;
    pc_rel  = 1'b0;
    case (ins[6:0])
      OP_LOAD, OP_OPIMM, OP_JALR: begin
        // JALR needs rs1, so it never gets a target here
        dec.fmt = FMT_I;
        imm32   = {{20{ins[31]}}, ins[31:20]};
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        imm32   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B;
        imm32   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        pc_rel  = 1'b1;
      end
      OP_LUI: begin
        dec.fmt = FMT_U;
        imm32   = {ins[31:12], 12'b0};
      end
      OP_AUIPC: begin
        dec.fmt = FMT_U;
        imm32   = {ins[31:12], 12'b0};
        pc_rel  = 1'b1;
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        imm32   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        pc_rel  = 1'b1;
      end
      default: begin
        dec.fmt     = FMT_NONE;
        dec.illegal = 1'b1;
      end
    endcase
    // Sign extension from bit 31 up to XLEN (no-op width-wise for XLEN=32)
    dec.imm    = XLEN'($signed(imm32));
    dec.target = pc_rel ? (bus.pc + dec.imm) : '0;
  end

  // Ready chain: a stage loads when empty or when the stage after it loads
  always_comb begin
    logic chain;
    chain = bus.out_ready;
    ld    = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain = chain | ~valid_q[k];
      ld[k] = chain;
    end
  end

  // Source of each stage: decode for stage 1, previous stage otherwise
  always_comb begin
    up_valid    = '0;
    up_data     = '{default: '0};
    up_valid[0] = bus.in_valid;
    up_data[0]  = dec;
    for (int k = 1; k < STAGES; k++) begin
      up_valid[k] = valid_q[k-1];
      up_data[k]  = data_q[k-1];
    end
  end

  // Stage registers; flush drops every valid bit including a same-cycle push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (bus.flush) begin
          valid_q[k] <= 1'b0;
        end else if (ld[k]) begin
          valid_q[k] <= up_valid[k];
        end
        if (ld[k] && up_valid[k]) begin
          data_q[k] <= up_data[k];
        end
      end
    end
  end

  assign bus.in_ready  = ld[0];
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.Imm       = data_q[STAGES-1].imm;
  assign bus.target    = data_q[STAGES-1].target;
  assign bus.fmt       = data_q[STAGES-1].fmt;
  assign bus.illegal   = data_q[STAGES-1].illegal;

endmodule

// File: tb/tb_generador_inmediato_pipe.sv
// Bench for generador_inmediato_pipe: three configurations
// (XLEN=32/STAGES=1, XLEN=32/STAGES=2, XLEN=64/STAGES=3).
module tb_generador_inmediato_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  generador_inmediato_pipe_if #(.XLEN(32)) b1 ();
  generador_inmediato_pipe_if #(.XLEN(32)) b2 ();
  generador_inmediato_pipe_if #(.XLEN(64)) b3 ();

  generador_inmediato_pipe #(.XLEN(32), .STAGES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  generador_inmediato_pipe #(.XLEN(32), .STAGES(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  generador_inmediato_pipe #(.XLEN(64), .STAGES(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference decode from the ISA field rules using plain integer arithmetic
  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] target;
    logic        ill;
  } exp_t;

  function automatic exp_t ref_dec(input logic [31:0] i, input logic [63:0] pc, input int xlen);
    exp_t   e;
    longint v;
    logic   rel;
    e   = '{imm: 64'd0, fmt: 3'd0, target: 64'd0, ill: 1'b0};
    v   = 0;
    rel = 1'b0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67: begin
        e.fmt = 3'd1;
        v = longint'(i[31:20]);
        if (v >= 2048) v = v - 4096;
      end
      7'h23: begin
        e.fmt = 3'd2;
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        if (v >= 2048) v = v - 4096;
      end
      7'h63: begin
        e.fmt = 3'd3; rel = 1'b1;
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        if (v >= 4096) v = v - 8192;
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4; rel = (i[6:0] == 7'h17);
        v = longint'(i[31:12]) * 4096;
        if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
      end
      7'h6F: begin
        e.fmt = 3'd5; rel = 1'b1;
        v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        if (v >= 1048576) v = v - 2097152;
      end
      default: e.ill = 1'b1;
    endcase
    e.imm    = 64'(v);
    e.target = rel ? (pc + e.imm) : 64'd0;
    if (xlen == 32) begin
      e.imm    = e.imm & 64'h0000_0000_FFFF_FFFF;
      e.target = e.target & 64'h0000_0000_FFFF_FFFF;
    end
    return e;
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [31:0] tgt;
    logic        ill;
  } vec_t;

  typedef struct {
    exp_t e;
    int   t;
  } ent_t;

  vec_t        tv [6];
  ent_t        q [$];
  logic [6:0]  ops [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};
  logic [31:0] x64_ins [2];
  logic [63:0] x64_imm [2];
  logic [31:0] r;
  logic [6:0]  op;
  logic        iv, ordy, fl, exp_rdy, exp_ov, got;
  int          acc, popped, idx;

  initial begin
    tv[0] = '{32'hFFF00093, 32'h0,   32'hFFFFFFFF, 3'd1, 32'h0,    1'b0};
    tv[1] = '{32'hFE112E23, 32'h0,   32'hFFFFFFFC, 3'd2, 32'h0,    1'b0};
    tv[2] = '{32'hFE000CE3, 32'h100, 32'hFFFFFFF8, 3'd3, 32'hF8,   1'b0};
    tv[3] = '{32'h123450B7, 32'h0,   32'h12345000, 3'd4, 32'h0,    1'b0};
    tv[4] = '{32'h0010006F, 32'h1000, 32'h00000800, 3'd5, 32'h1800, 1'b0};
    tv[5] = '{32'h00000000, 32'h0,   32'h0,        3'd0, 32'h0,    1'b1};
    x64_ins[0] = 32'hFFF00093; x64_imm[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    x64_ins[1] = 32'h800000B7; x64_imm[1] = 64'hFFFF_FFFF_8000_0000;

    b1.flush = 0; b1.in_valid = 0; b1.instruction = 0; b1.pc = 0; b1.out_ready = 1;
    b2.flush = 0; b2.in_valid = 0; b2.instruction = 0; b2.pc = 0; b2.out_ready = 1;
    b3.flush = 0; b3.in_valid = 0; b3.instruction = 0; b3.pc = 0; b3.out_ready = 1;

    // Reset held with a valid offer on the STAGES=1 instance
    rst_n = 1'b0;
    b1.in_valid = 1; b1.instruction = 32'hFFF00093;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_out_valid", b1.out_valid, 0);
    chk("rst_imm", b1.Imm, 0);
    chk("rst_fmt", b1.fmt, 0);
    chk("rst_in_ready", b1.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", b1.in_ready, 1);
    chk("rel_out_valid", b1.out_valid, 0);
    @(negedge clk);
    b1.in_valid = 0;
    #1;
    chk("s1_latency_valid", b1.out_valid, 1);
    chk("s1_imm", b1.Imm, 32'hFFFFFFFF);
    chk("s1_fmt", b1.fmt, 1);
    @(negedge clk); #1;
    chk("s1_drained", b1.out_valid, 0);

    // Format table on XLEN=32, STAGES=2
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b2.in_valid = 1; b2.instruction = tv[i].ins; b2.pc = tv[i].pc; b2.out_ready = 1;
      #1;
      chk("tbl_in_ready", b2.in_ready, 1);
      @(negedge clk);
      b2.in_valid = 0;
      #1;
      chk("tbl_early_valid", b2.out_valid, 0);
      @(negedge clk); #1;
      chk("tbl_out_valid", b2.out_valid, 1);
      chk("tbl_imm", b2.Imm, tv[i].imm);
      chk("tbl_fmt", b2.fmt, tv[i].fmt);
      chk("tbl_target", b2.target, tv[i].tgt);
      chk("tbl_illegal", b2.illegal, tv[i].ill);
    end

    // XLEN=64 sign extension
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      b3.in_valid = 1; b3.instruction = x64_ins[i]; b3.pc = 0; b3.out_ready = 1;
      @(negedge clk);
      b3.in_valid = 0;
      got = 0;
      for (int c = 0; c < 8 && !got; c++) begin
        #1;
        if (b3.out_valid) begin
          got = 1;
          chk("x64_imm", b3.Imm, x64_imm[i]);
        end else begin
          @(negedge clk);
        end
      end
      if (!got) chk("x64_timeout", 0, 1);
    end

    // Backpressure, STAGES=3: only three accepts while out_ready=0
    @(negedge clk);
    b3.out_ready = 0; b3.pc = 0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      b3.in_valid = 1; b3.instruction = {12'(acc + 1), 20'h00093};
      #1;
      chk("bp_in_ready", b3.in_ready, 64'(acc < 3));
      if (b3.in_ready) acc++;
      @(negedge clk);
    end
    chk("bp_accepts", acc, 3);
    #1;
    chk("bp_stall_valid", b3.out_valid, 1);
    chk("bp_stall_imm", b3.Imm, 1);
    @(negedge clk);
    b3.out_ready = 1;
    popped = 0;
    for (int c = 0; c < 15 && popped < 5; c++) begin
      b3.in_valid = (acc < 5); b3.instruction = {12'(acc + 1), 20'h00093};
      #1;
      if (b3.out_valid) begin
        chk("bp_order", b3.Imm, 64'(popped + 1));
        popped++;
      end
      if (b3.in_valid && b3.in_ready) acc++;
      @(negedge clk);
    end
    b3.in_valid = 0;
    chk("bp_count", popped, 5);
    #1;
    chk("bp_no_dup", b3.out_valid, 0);

    // Flush with a full pipe and a same-cycle push/pop
    @(negedge clk);
    b3.out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      b3.in_valid = 1; b3.instruction = {12'(16'h11 + c), 20'h00093};
      @(negedge clk);
    end
    b3.in_valid = 1; b3.instruction = {12'h014, 20'h00093};
    b3.out_ready = 1; b3.flush = 1;
    #1;
    chk("fl_in_ready", b3.in_ready, 1);
    @(negedge clk);
    b3.flush = 0; b3.in_valid = 0;
    #1;
    chk("fl_out_valid", b3.out_valid, 0);
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    chk("fl_stays_empty", b3.out_valid, 0);
    @(negedge clk);
    b3.in_valid = 1; b3.instruction = {12'h055, 20'h00093};
    @(negedge clk);
    b3.in_valid = 0;
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      #1;
      if (b3.out_valid) begin
        got = 1;
        chk("fl_first_out", b3.Imm, 64'h55);
      end else begin
        @(negedge clk);
      end
    end
    if (!got) chk("fl_timeout", 0, 1);

    // Randomised traffic on XLEN=64, STAGES=3 against a timestamped queue model
    q.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      r   = $urandom();
      idx = $urandom_range(0, 9);
      op  = ($urandom_range(0, 5) == 0) ? r[6:0] : ops[idx];
      b3.instruction = {r[31:7], op};
      b3.pc = {$urandom(), $urandom()};
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 24) == 0);
      if (fl) ordy = 0;
      b3.in_valid = iv; b3.out_ready = ordy; b3.flush = fl;
      #1;
      exp_rdy = (q.size() < 3) || ordy;
      exp_ov  = (q.size() > 0) && ((cyc - q[0].t - 1) >= 2);
      chk("rnd_in_ready", b3.in_ready, exp_rdy);
      chk("rnd_out_valid", b3.out_valid, exp_ov);
      if (exp_ov && b3.out_valid) begin
        chk("rnd_imm", b3.Imm, q[0].e.imm);
        chk("rnd_target", b3.target, q[0].e.target);
        chk("rnd_fmt", b3.fmt, q[0].e.fmt);
        chk("rnd_illegal", b3.illegal, q[0].e.ill);
      end
      if (fl) begin
        q.delete();
      end else begin
        if (exp_ov && ordy) void'(q.pop_front());
        if (iv && exp_rdy) q.push_back('{ref_dec(b3.instruction, b3.pc, 64), cyc});
      end
    end
    @(negedge clk);
    b3.in_valid = 0; b3.flush = 0; b3.out_ready = 1;

    // Asynchronous reset between clock edges while a result is held
    @(negedge clk);
    b1.in_valid = 1; b1.instruction = 32'h00700093; b1.out_ready = 0;
    @(negedge clk);
    b1.in_valid = 0;
    #1;
    chk("ar_pre_valid", b1.out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", b1.out_valid, 0);
    chk("ar_imm", b1.Imm, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
